ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. Takes the current PC, issues one read request per instruction on a valid/ready memory port, captures the response and presents the instruction (with its PC) to decode on a valid/ready handshake. Generates the PC advance enable and supports a flush/redirect that discards any in-flight fetch.

## Interface
- WIDTH, 32, address/PC width
- NOP_INST, 32'h00000013, instruction word presented alongside a fault
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  WIDTH  current PC; changes only after a pc_en pulse or a redirect
- pc_en  out  1  one-cycle PC advance enable (PC <= PC+4 at the same edge)
- flush  in  1  redirect; the PC is rewritten externally at the same edge
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  WIDTH  request address
- mem_rsp_valid  in  1  read data valid (one response per accepted request, in order)
- mem_rsp_data  in  32  read data
- mem_rsp_err  in  1  access fault on this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  WIDTH  address the instruction was fetched from
- inst_fault  out  1  fetch fault flag

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD. Reset state IDLE.
- IDLE: no outputs asserted; next state REQ unconditionally (one bubble).
- REQ: mem_req_valid=1, mem_req_addr=pc (combinational).
  - Handshake (valid&ready) and no flush: latch req_pc<=pc -> WAIT.
  - Handshake and flush: -> DRAIN (the accepted response is owed, must be discarded).
  - No handshake and flush: -> IDLE (request withdrawn; new pc used after the bubble).
  - No handshake, no flush: stay; addr stable.
- WAIT: mem_rsp_* sampled only in WAIT/DRAIN.
  - rsp_valid, no flush: inst<=err?NOP_INST:rsp_data, inst_pc<=req_pc, inst_fault<=rsp_err -> HOLD.
  - rsp_valid and flush: discard -> IDLE.
  - flush, no rsp: -> DRAIN.
- DRAIN: wait for rsp_valid, discard data -> IDLE. Flush in DRAIN is ignored (stay DRAIN).
- HOLD: inst_valid=1; inst/inst_pc/inst_fault held stable.
  - flush (priority over inst_ready): drop instruction, pc_en=0 -> IDLE.
  - inst_ready, no flush: pc_en=1 for this cycle -> REQ.
  - otherwise stay.
- pc_en asserts only in HOLD with inst_ready&~flush; never on flush.
- At most one outstanding memory request at any time.
- Fault does not stop fetching; decode handles the trap and redirects via flush.

## Timing
- Reset (async, immediate): state=IDLE; mem_req_valid=0, inst_valid=0, pc_en=0, inst_fault=0, inst=0, inst_pc=0, req_pc=0, mem_req_addr=pc (don't-care while valid=0).
- Zero-wait-memory sequence: cycle t REQ handshake; t+1 WAIT with rsp_valid; t+2 HOLD, inst_valid=1, handoff with inst_ready; t+3 REQ with pc+4. Throughput 1 instruction / 3 cycles; first request one cycle after reset release.
- mem_req_valid and inst_valid are decodes of registered state: no combinational path from any input to any valid.
- pc_en and mem_req_addr are combinational (state & inputs / pc).
- Response arriving outside WAIT/DRAIN is a protocol violation; ignored.
- Reset mid-operation: outstanding response is abandoned; memory side is reset by the same rst.

## Test plan
- Reset: assert rst mid-HOLD -> inst_valid=0, mem_req_valid=0 immediately; after release, mem_req_valid=1 on 2nd edge with addr=pc (e.g. 0x80000000).
- Straight-line: ready memory returns 0x00100093 at 0x80000000 -> inst=0x00100093, inst_pc=0x80000000, pc_en one cycle, next request addr 0x80000004 three cycles after the first.
- Backpressure: inst_ready low 5 cycles in HOLD -> inst/inst_pc stable, pc_en=0, no new request; inst_ready high -> single pc_en pulse.
- Memory stalls: mem_req_ready low 4 cycles, rsp 3 cycles after accept -> addr stable while waiting, exactly one request, correct inst delivered.
- Flush in WAIT: flush then rsp 0xDEADBEEF two cycles later -> never presented; next request addr = redirected pc (e.g. 0x80001000), no pc_en.
- Fault: rsp_err=1 -> inst=0x00000013, inst_fault=1, inst_pc=faulting address; flush with inst_ready in HOLD -> no pc_en, state IDLE.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage between the PC register and decode.
// Keeps at most one memory read in flight and hands each word to decode.
module ifu_fetch #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  input  logic             mem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] req_pc_q;
  logic [31:0]      inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic             inst_fault_q;

  logic req_fire;
  logic in_req;
  logic in_hold;

  assign in_req   = (state_q == S_REQ);
  assign in_hold  = (state_q == S_HOLD);
  assign req_fire = in_req & mem_req_ready;

  // Valids are pure state decodes so decode and memory never see
  // a combinational loop back through their ready inputs.
  assign mem_req_valid = in_req;
  assign mem_req_addr  = pc;
  assign inst_valid    = in_hold;
  assign pc_en         = in_hold & inst_ready & ~flush;

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_pc_q     <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (req_fire) begin
            if (flush) begin
              state_q <= S_DRAIN;
            end else begin
              req_pc_q <= pc;
              state_q  <= S_WAIT;
            end
          end else if (flush) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              inst_q       <= mem_rsp_err ? NOP_INST
                                          : mem_rsp_data;
              inst_pc_q    <= req_pc_q;
              inst_fault_q <= mem_rsp_err;
              state_q      <= S_HOLD;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        // The owed response must be swallowed even if redirected again.
        S_DRAIN: begin
          if (mem_rsp_valid) begin
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (inst_ready) begin
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: vector table, hand sequences and a randomized run
// against a program-order fetch model with a latency memory.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .pc_en         (pc_en),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p,
                       input logic f,
                       input logic rdy,
                       input logic rv,
                       input logic [31:0] rd,
                       input logic re,
                       input logic ir);
    pc            = p;
    flush         = f;
    mem_req_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    mem_rsp_err   = re;
    inst_ready    = ir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(A, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("rst_req_valid", mem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_fault", inst_fault, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        f, rdy, rv;
    logic [31:0] rd;
    logic        re, ir;
    logic        e_rv, e_iv, e_pe;
    logic [31:0] e_inst, e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t v[$];

  function automatic void add(
    input logic [31:0] p, input logic f,
    input logic rdy, input logic rv,
    input logic [31:0] rd, input logic re,
    input logic ir, input logic erv,
    input logic eiv, input logic epe,
    input logic [31:0] ei, input logic [31:0] eipc,
    input logic eflt);
    vec_t t;
    t.pc = p;  t.f = f;  t.rdy = rdy;
    t.rv = rv; t.rd = rd; t.re = re; t.ir = ir;
    t.e_rv = erv; t.e_iv = eiv; t.e_pe = epe;
    t.e_inst = ei; t.e_ipc = eipc; t.e_flt = eflt;
    v.push_back(t);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'd7;
  endfunction

  typedef struct {
    logic [31:0] a;
    int          cnt;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] rpc;
  logic [31:0] hold_inst;
  int          delivered;

  initial begin
    rst = 1'b1;
    drive(A, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // pc, f, rdy, rv, rd, re, ir | req_v, inst_v, pc_en, inst, inst_pc, flt
    add(A,      0,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A,      0,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A,      0,1'b0,1,32'h0010_0093,0,0, 0,0,0, '0,'0,0);
    add(A,      0,1'b0,0,'0,0,1, 0,1,1, 32'h0010_0093,A,0);
    add(A+4,    0,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A+4,    0,1'b0,1,32'h1234_5678,1,0, 0,0,0, '0,'0,0);
    add(A+4,    0,1'b0,0,'0,0,0, 0,1,0, NOP,A+4,1);
    add(A+4,    1,1'b0,0,'0,0,1, 0,1,0, NOP,A+4,1);
    add(A+32'h1000,0,1'b0,0,'0,0,1, 0,0,0, '0,'0,0);
    add(A+32'h1000,0,1'b0,1,32'hDEAD_BEEF,0,0, 1,0,0, '0,'0,0);
    add(A+32'h1000,1,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A+32'h2000,1,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A+32'h2000,0,1'b0,1,32'hDEAD_BEEF,0,1, 0,0,0, '0,'0,0);
    add(A+32'h2000,0,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A+32'h2000,0,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A+32'h2000,1,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A+32'h3000,0,1'b0,1,32'hDEAD_BEEF,0,0, 0,0,0, '0,'0,0);
    add(A+32'h3000,0,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A+32'h3000,0,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A+32'h3000,1,1'b0,1,32'hDEAD_BEEF,0,0, 0,0,0, '0,'0,0);
    add(A+32'h4000,0,1'b0,0,'0,0,0, 0,0,0, '0,'0,0);
    add(A+32'h4000,0,1'b1,0,'0,0,0, 1,0,0, '0,'0,0);
    add(A+32'h4000,0,1'b0,1,32'hABCD_EF01,0,1, 0,0,0, '0,'0,0);
    add(A+32'h4000,0,1'b0,0,'0,0,1, 0,1,1, 32'hABCD_EF01,A+32'h4000,0);
    add(A+32'h4004,0,1'b0,0,'0,0,0, 1,0,0, '0,'0,0);

    do_reset();
    foreach (v[i]) begin
      drive(v[i].pc, v[i].f, v[i].rdy, v[i].rv,
            v[i].rd, v[i].re, v[i].ir);
      #1;
      chk1($sformatf("v%0d_req_valid", i), mem_req_valid, v[i].e_rv);
      chk1($sformatf("v%0d_inst_valid", i), inst_valid, v[i].e_iv);
      chk1($sformatf("v%0d_pc_en", i), pc_en, v[i].e_pe);
      if (v[i].e_rv)
        chk32($sformatf("v%0d_addr", i), mem_req_addr, v[i].pc);
      if (v[i].e_iv) begin
        chk32($sformatf("v%0d_inst", i), inst, v[i].e_inst);
        chk32($sformatf("v%0d_inst_pc", i), inst_pc, v[i].e_ipc);
        chk1($sformatf("v%0d_fault", i), inst_fault, v[i].e_flt);
      end
      @(negedge clk);
    end

    // Reset asserted asynchronously while an instruction is held
    do_reset();
    drive(A, 0, 0, 0, '0, 0, 0);
    @(negedge clk);
    drive(A, 0, 1, 0, '0, 0, 0);
    @(negedge clk);
    drive(A, 0, 0, 1, 32'h0010_0093, 0, 0);
    @(negedge clk);
    drive(A, 0, 0, 0, '0, 0, 1'b0);
    #1;
    chk1("hold_before_rst", inst_valid, 1'b1);
    inst_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk1("async_rst_inst_valid", inst_valid, 1'b0);
    chk1("async_rst_req_valid", mem_req_valid, 1'b0);
    chk1("async_rst_pc_en", pc_en, 1'b0);
    chk32("async_rst_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(A, 0, 0, 0, '0, 0, 0);
    #1;
    chk1("post_rst_idle", mem_req_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("post_rst_req", mem_req_valid, 1'b1);
    chk32("post_rst_addr", mem_req_addr, A);

    // Memory stall, slow response, then decode backpressure
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(A, 0, 0, 0, '0, 0, 0);
      #1;
      chk1("stall_req_valid", mem_req_valid, 1'b1);
      chk32("stall_addr", mem_req_addr, A);
    end
    @(negedge clk);
    drive(A, 0, 1, 0, '0, 0, 0);
    #1;
    chk1("stall_accept", mem_req_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(A, 0, 1, k == 2, 32'h0020_0113, 0, 0);
      #1;
      chk1("wait_no_req", mem_req_valid, 1'b0);
      chk1("wait_no_inst", inst_valid, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(A, 0, 1, 0, '0, 0, 0);
      #1;
      chk1("bp_inst_valid", inst_valid, 1'b1);
      chk32("bp_inst", inst, 32'h0020_0113);
      chk32("bp_inst_pc", inst_pc, A);
      chk1("bp_pc_en", pc_en, 1'b0);
      chk1("bp_no_req", mem_req_valid, 1'b0);
    end
    @(negedge clk);
    drive(A, 0, 1, 0, '0, 0, 1);
    #1;
    chk1("bp_release_pc_en", pc_en, 1'b1);
    @(negedge clk);
    drive(A + 4, 0, 0, 0, '0, 0, 1);
    #1;
    chk1("bp_single_pulse", pc_en, 1'b0);
    chk1("bp_next_req", mem_req_valid, 1'b1);
    chk32("bp_next_addr", mem_req_addr, A + 4);

    // Randomized run: the bench plays PC register and memory
    do_reset();
    rpc       = A;
    delivered = 0;
    pq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        f, ir, rdy, rv, re;
      logic [31:0] rd;
      pend_t       e;
      f   = ($urandom_range(0, 19) == 0);
      ir  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = 1'b0;
      rd  = $urandom();
      re  = 1'($urandom_range(0, 1));
      if (pq.size() > 0) begin
        if (pq[0].cnt == 0) begin
          rv = 1'b1;
          rd = mem_word(pq[0].a);
          re = mem_err(pq[0].a);
        end
      end
      drive(rpc, f, rdy, rv, rd, re, ir);
      #1;
      chk1("r_pc_en", pc_en, inst_valid & ir & ~f);
      chk1("r_one_valid", mem_req_valid & inst_valid, 1'b0);
      if (mem_req_valid)
        chk32("r_addr", mem_req_addr, rpc);
      if (inst_valid) begin
        hold_inst = mem_err(rpc) ? NOP : mem_word(rpc);
        chk32("r_inst_pc", inst_pc, rpc);
        chk32("r_inst", inst, hold_inst);
        chk1("r_fault", inst_fault, mem_err(rpc));
        if (ir && !f) delivered++;
      end
      if (rv) begin
        void'(pq.pop_front());
      end else if (pq.size() > 0) begin
        pq[0].cnt = pq[0].cnt - 1;
      end
      if (mem_req_valid && rdy) begin
        chk32("r_outstanding", 32'(pq.size()), 32'd0);
        e.a   = rpc;
        e.cnt = int'($urandom_range(0, 3));
        pq.push_back(e);
      end
      if (f)
        rpc = A | ($urandom_range(0, 1023) << 2);
      else if (pc_en)
        rpc = rpc + 32'd4;
      @(negedge clk);
    end
    chk1("r_progress", delivered >= 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
